// File: rtl/alu_run_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_run_pkg : shared types, page indices and LED codes for alu_run_ctrl     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package alu_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    EXEC  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam logic [2:0] PG_B0    = 3'd0;
  localparam logic [2:0] PG_B1    = 3'd1;
  localparam logic [2:0] PG_B2    = 3'd2;
  localparam logic [2:0] PG_B3    = 3'd3;
  localparam logic [2:0] PG_FLAGS = 3'd4;

  localparam logic [7:0] LED_IDLE  = 8'h00;
  localparam logic [7:0] LED_GOT_A = 8'h01;
  localparam logic [7:0] LED_EXEC  = 8'h80;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] page_byte(input logic [31:0] res,
                                           input logic        zf,
                                           input logic        of,
                                           input logic [2:0]  sel);
    logic [7:0] b;
    case (sel)
      PG_B0:   b = res[7:0];
      PG_B1:   b = res[15:8];
      PG_B2:   b = res[23:16];
      PG_B3:   b = res[31:24];
      default: b = {zf, 6'b000000, of};
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_run_ctrl_disp_scan_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_scan_timer : divides the clock into display pages, sel wraps 0..4     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module disp_scan_timer
  import alu_run_pkg::*;
#(
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] sel
);

  localparam int              c_cw   = cnt_w(SCAN_DIV);
  localparam logic [c_cw-1:0] c_term = c_cw'(SCAN_DIV - 1);

  logic [c_cw-1:0] r_cnt;
  logic [2:0]      r_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= PG_B0;
    end else if (clear) begin
      r_cnt <= '0;
      r_sel <= PG_B0;
    end else if (en) begin
      if (r_cnt == c_term) begin
        r_cnt <= '0;
        r_sel <= (r_sel == PG_FLAGS) ? PG_B0 : r_sel + 3'd1;
      end else begin
        r_cnt <= r_cnt + c_cw'(1);
      end
    end
  end

  assign sel = r_sel;

endmodule
`default_nettype wire

// File: rtl/alu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_run_ctrl : loads A/B/op from switches, times the ALU, scans result LEDs |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module alu_run_ctrl
  import alu_run_pkg::*;
#(
  parameter int ALU_LAT  = 1,
  parameter int SCAN_DIV = 50_000_000,
  parameter int OP_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_load,
  input  logic [31:0]     sw_data,
  input  logic [OP_W-1:0] sw_op,
  input  logic            hold,
  input  logic [31:0]     alu_f,
  input  logic            alu_zf,
  input  logic            alu_of,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic [7:0]      led,
  output logic [2:0]      disp_sel,
  output logic            busy,
  output logic            done
);

  localparam int              c_lw       = cnt_w(ALU_LAT);
  localparam logic [c_lw-1:0] c_lat_last = c_lw'(ALU_LAT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_load_a;
  logic            w_load_b;
  logic            w_sample;
  logic [7:0]      w_led_nxt;
  logic [2:0]      w_sel;
  logic [c_lw-1:0] r_lat_cnt;
  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  logic [OP_W-1:0] r_alu_op;
  logic [31:0]     r_res;
  logic            r_zf;
  logic            r_of;
  logic [7:0]      r_led;
  logic            r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_sample    = 1'b0;
    w_led_nxt   = LED_IDLE;
    case (r_state)
      IDLE: begin
        if (key_load) begin
          w_load_a    = 1'b1;
          w_state_nxt = GOT_A;
        end
      end
      GOT_A: begin
        w_led_nxt = LED_GOT_A;
        if (key_load) begin
          w_load_b    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      // key_load is deliberately not decoded here: operands stay stable for the ALU.
      EXEC: begin
        w_led_nxt = LED_EXEC;
        if (r_lat_cnt == c_lat_last) begin
          w_sample    = 1'b1;
          w_state_nxt = SHOW;
        end
      end
      SHOW: begin
        w_led_nxt = page_byte(r_res, r_zf, r_of, w_sel);
        if (key_load) begin
          w_load_a    = 1'b1;
          w_state_nxt = GOT_A;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_lat_cnt <= '0;
      r_res     <= '0;
      r_zf      <= 1'b0;
      r_of      <= 1'b0;
      r_led     <= LED_IDLE;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_sample;
      r_led  <= w_led_nxt;
      if (w_load_a) r_alu_a <= sw_data;
      if (w_load_b) begin
        r_alu_b  <= sw_data;
        r_alu_op <= sw_op;
      end
      if (w_load_b)              r_lat_cnt <= '0;
      else if (r_state == EXEC)  r_lat_cnt <= r_lat_cnt + c_lw'(1);
      if (w_sample) begin
        r_res <= alu_f;
        r_zf  <= alu_zf;
        r_of  <= alu_of;
      end
    end
  end

  disp_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_sample),
    .en    ((r_state == SHOW) && !hold),
    .sel   (w_sel)
  );

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign led      = r_led;
  assign disp_sel = w_sel;
  assign busy     = (r_state == EXEC);
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_run_ctrl : two configurations (LAT3/DIV4 and LAT1/DIV1) side by side |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_alu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_load;
  logic        hold;
  logic [31:0] sw_data;
  logic [3:0]  sw_op;

  logic [31:0] a_o    [2];
  logic [31:0] b_o    [2];
  logic [3:0]  op_o   [2];
  logic [7:0]  led_o  [2];
  logic [2:0]  sel_o  [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic [33:0] alu_r  [2];

  int lat_v [2] = '{3, 1};
  int div_v [2] = '{4, 1};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Lab ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, else XOR. Returns {zf, of, f}.
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [31:0] f;
    logic        of;
    of = 1'b0;
    case (op)
      4'd0: begin f = a + b; of = (a[31] == b[31]) && (f[31] != a[31]); end
      4'd1: begin f = a - b; of = (a[31] != b[31]) && (f[31] != a[31]); end
      4'd2: f = a & b;
      4'd3: f = a | b;
      default: f = a ^ b;
    endcase
    return {(f == 32'd0), of, f};
  endfunction

  function automatic logic [7:0] exp_page(input logic [33:0] r, input int p);
    logic [31:0] f;
    f = r[31:0];
    if (p < 4) return f[8*p +: 8];
    return {r[33], 6'b000000, r[32]};
  endfunction

  assign alu_r[0] = alu_ref(a_o[0], b_o[0], op_o[0]);
  assign alu_r[1] = alu_ref(a_o[1], b_o[1], op_o[1]);

  alu_run_ctrl #(.ALU_LAT(3), .SCAN_DIV(4), .OP_W(4)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .sw_data  (sw_data),
    .sw_op    (sw_op),
    .hold     (hold),
    .alu_f    (alu_r[0][31:0]),
    .alu_zf   (alu_r[0][33]),
    .alu_of   (alu_r[0][32]),
    .alu_a    (a_o[0]),
    .alu_b    (b_o[0]),
    .alu_op   (op_o[0]),
    .led      (led_o[0]),
    .disp_sel (sel_o[0]),
    .busy     (busy_o[0]),
    .done     (done_o[0])
  );

  alu_run_ctrl #(.ALU_LAT(1), .SCAN_DIV(1), .OP_W(4)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .sw_data  (sw_data),
    .sw_op    (sw_op),
    .hold     (hold),
    .alu_f    (alu_r[1][31:0]),
    .alu_zf   (alu_r[1][33]),
    .alu_of   (alu_r[1][32]),
    .alu_a    (a_o[1]),
    .alu_b    (b_o[1]),
    .alu_op   (op_o[1]),
    .led      (led_o[1]),
    .disp_sel (sel_o[1]),
    .busy     (busy_o[1]),
    .done     (done_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d alu_a", tag, d), a_o[d], 32'd0);
      chk($sformatf("%s d%0d alu_b", tag, d), b_o[d], 32'd0);
      chk($sformatf("%s d%0d alu_op", tag, d), 32'(op_o[d]), 32'd0);
      chk($sformatf("%s d%0d led", tag, d), 32'(led_o[d]), 32'd0);
      chk($sformatf("%s d%0d sel", tag, d), 32'(sel_o[d]), 32'd0);
      chk($sformatf("%s d%0d busy", tag, d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("%s d%0d done", tag, d), 32'(done_o[d]), 32'd0);
    end
  endtask

  // One full operation starting from IDLE or SHOW; both DUTs end in SHOW.
  // hmode: 0 no hold, 1 random hold, 2 hold for 10 cycles from hstart.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input int hmode, input int hstart, input int ncyc, input bit ign);
    logic [33:0] er;
    int          adv [2];
    int          adv_prev;
    bit          hs;
    er = alu_ref(a, b, op);

    sw_data = a; key_load = 1'b1; tick(); key_load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d load_a", d), a_o[d], a);
      chk($sformatf("d%0d busy got_a", d), 32'(busy_o[d]), 32'd0);
    end
    sw_data = $urandom; tick();
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d led got_a", d), 32'(led_o[d]), 32'h01);

    sw_data = b; sw_op = op; key_load = 1'b1; tick(); key_load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d load_b", d), b_o[d], b);
      chk($sformatf("d%0d load_op", d), 32'(op_o[d]), 32'(op));
      chk($sformatf("d%0d busy c0", d), 32'(busy_o[d]), 32'd1);
      chk($sformatf("d%0d done c0", d), 32'(done_o[d]), 32'd0);
    end
    // Load pulse landing on the first EXEC edge must be ignored by both.
    if (ign) begin sw_data = ~b; key_load = 1'b1; end

    adv[0] = 0; adv[1] = 0;
    for (int c = 1; c <= ncyc; c++) begin
      case (hmode)
        1:       hold = ($urandom_range(0, 2) == 0);
        2:       hold = (c >= hstart) && (c < hstart + 10);
        default: hold = 1'b0;
      endcase
      hs = hold;
      tick(); key_load = 1'b0;
      for (int d = 0; d < 2; d++) begin
        adv_prev = adv[d];
        if (c > lat_v[d] && !hs) adv[d]++;
        chk($sformatf("d%0d busy c%0d", d, c), 32'(busy_o[d]), 32'(c < lat_v[d]));
        chk($sformatf("d%0d done c%0d", d, c), 32'(done_o[d]), 32'(c == lat_v[d]));
        chk($sformatf("d%0d keep_a c%0d", d, c), a_o[d], a);
        chk($sformatf("d%0d keep_b c%0d", d, c), b_o[d], b);
        if (c >= lat_v[d])
          chk($sformatf("d%0d sel c%0d", d, c), 32'(sel_o[d]), 32'((adv[d] / div_v[d]) % 5));
        if (c <= lat_v[d])
          chk($sformatf("d%0d led exec c%0d", d, c), 32'(led_o[d]), 32'h80);
        else
          chk($sformatf("d%0d led page c%0d", d, c), 32'(led_o[d]),
              32'(exp_page(er, (adv_prev / div_v[d]) % 5)));
      end
    end
    hold = 1'b0;
  endtask

  task automatic reset_mid();
    sw_data = 32'hCAFE_0001; key_load = 1'b1; tick(); key_load = 1'b0;
    sw_data = 32'h0000_0002; sw_op = 4'd0; key_load = 1'b1; tick(); key_load = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    repeat (3) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d done in rst", d), 32'(done_o[d]), 32'd0);
        chk($sformatf("d%0d busy in rst", d), 32'(busy_o[d]), 32'd0);
      end
    end
    rst_n = 1'b1;
    tick();
    check_zero("post_rst");
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; hold = 1'b0; sw_data = '0; sw_op = '0;
    #2 check_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_zero("idle");

    run_op(32'h1234_5678, 32'h1111_1111, 4'd0, 0, 0, 32, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 0, 0, 30, 1'b1);
    run_op(32'h0000_0000, 32'h0000_0000, 4'd0, 0, 0, 30, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'd2, 2, 14, 45, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 4'd1, 0, 0, 30, 1'b1);
    reset_mid();
    run_op(32'hA5A5_0000, 32'h005A_5A5A, 4'd3, 1, 0, 34, 1'b0);
    for (int i = 0; i < 12; i++)
      run_op($urandom, $urandom, 4'($urandom_range(0, 4)), $urandom_range(0, 1), 0,
             $urandom_range(24, 40), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
